// File: rtl/stream_byte_packer_pkg.sv
// Shared constants, state encoding and keep-mask helpers for stream_byte_packer.
package stream_byte_packer_pkg;

    localparam int unsigned DATA_BYTES = 32;
    localparam int unsigned DATA_W     = 8 * DATA_BYTES;
    localparam int unsigned CNT_BITS   = $clog2(DATA_BYTES + 1);
    localparam int unsigned OCC_W      = CNT_BITS - 1;

    typedef enum logic {
        StAccum = 1'b0,
        StFlush = 1'b1
    } state_e;

    function automatic logic [CNT_BITS-1:0] keep_count(input logic [DATA_BYTES-1:0] keep);
        logic [CNT_BITS-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            cnt = cnt + CNT_BITS'(keep[i]);
        end
        return cnt;
    endfunction

    // n -> (1 << n) - 1, valid for n in 0..DATA_BYTES
    function automatic logic [DATA_BYTES-1:0] low_mask(input logic [CNT_BITS-1:0] n);
        logic [DATA_BYTES-1:0] m;
        for (int i = 0; i < DATA_BYTES; i++) begin
            m[i] = (CNT_BITS'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/stream_byte_packer_keep_popcount.sv
// Byte-valid mask to byte count, plus a flag for a low-contiguous mask.
module keep_popcount
    import stream_byte_packer_pkg::*;
(
    input  logic [DATA_BYTES-1:0] i_keep,
    output logic [CNT_BITS-1:0]   o_count,
    output logic                  o_contig
);

    assign o_count  = keep_count(i_keep);
    assign o_contig = (i_keep == low_mask(o_count));

endmodule

// File: rtl/stream_byte_packer.sv
// Repacks a sparse tkeep-marked byte stream into dense beats, preserving frames.
// Optional statistics counters are enabled by defining PACKER_STATS_EN.
module stream_byte_packer
    import stream_byte_packer_pkg::*;
`ifdef PACKER_STATS_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_BYTES-1:0] s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_W-1:0]     m_tdata,
    output logic [DATA_BYTES-1:0] m_tkeep,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  err_keep
`ifdef PACKER_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_bytes_in,
    output logic [CNT_W-1:0]      stat_beats_out,
    output logic [CNT_W-1:0]      stat_frames_out
`endif
);

    localparam int unsigned N_W = CNT_BITS + 1;
    localparam logic [N_W-1:0] FULL_N = N_W'(DATA_BYTES);

    state_e                r_state, w_state_d;
    logic [OCC_W-1:0]      r_occ, w_occ_d;
    logic [DATA_W-1:0]     r_buf, w_buf_d;
    logic [DATA_W-1:0]     r_m_tdata, w_m_tdata_d;
    logic [DATA_BYTES-1:0] r_m_tkeep, w_m_tkeep_d;
    logic                  r_m_tvalid, w_m_tvalid_d;
    logic                  r_m_tlast, w_m_tlast_d;
    logic                  r_err_keep;

    logic [CNT_BITS-1:0]   w_count;
    logic                  w_contig;
    logic [DATA_BYTES-1:0] w_keep_mask;
    logic [DATA_W-1:0]     w_in_masked;
    logic [2*DATA_W-1:0]   w_merge;
    logic [N_W-1:0]        w_n;
    logic                  w_out_free;
    logic                  w_accept;

    keep_popcount u_keep_popcount (
        .i_keep   (s_tkeep),
        .o_count  (w_count),
        .o_contig (w_contig)
    );

    // Take the low w_count bytes regardless of mask shape; bytes above are zeroed
    always_comb begin
        w_keep_mask = low_mask(w_count);
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_in_masked[8*i +: 8] = w_keep_mask[i] ? s_tdata[8*i +: 8] : 8'h00;
        end
    end

    // r_buf holds only r_occ valid bytes with the rest zero, so OR-merge is safe
    assign w_merge = {{DATA_W{1'b0}}, r_buf}
                   | ({{DATA_W{1'b0}}, w_in_masked} << {r_occ, 3'b000});
    assign w_n        = N_W'(r_occ) + N_W'(w_count);
    assign w_out_free = !r_m_tvalid || m_tready;
    assign s_tready   = !reset && (r_state == StAccum) && w_out_free;
    assign w_accept   = s_tvalid && s_tready;

    always_comb begin
        w_state_d    = r_state;
        w_occ_d      = r_occ;
        w_buf_d      = r_buf;
        w_m_tdata_d  = r_m_tdata;
        w_m_tkeep_d  = r_m_tkeep;
        w_m_tlast_d  = r_m_tlast;
        w_m_tvalid_d = r_m_tvalid && !m_tready;
        case (r_state)
            StAccum: begin
                if (w_accept) begin
                    if (w_n >= FULL_N) begin
                        w_m_tvalid_d = 1'b1;
                        w_m_tdata_d  = w_merge[DATA_W-1:0];
                        w_m_tkeep_d  = '1;
                        w_m_tlast_d  = s_tlast && (w_n == FULL_N);
                        w_occ_d      = OCC_W'(w_n - FULL_N);
                        w_buf_d      = w_merge[2*DATA_W-1:DATA_W];
                        if (s_tlast && (w_n != FULL_N)) begin
                            w_state_d = StFlush;
                        end
                    end else if (s_tlast) begin
                        w_m_tvalid_d = 1'b1;
                        w_m_tdata_d  = w_merge[DATA_W-1:0];
                        w_m_tkeep_d  = low_mask(w_n[CNT_BITS-1:0]);
                        w_m_tlast_d  = 1'b1;
                        w_occ_d      = '0;
                        w_buf_d      = '0;
                    end else begin
                        w_occ_d = w_n[OCC_W-1:0];
                        w_buf_d = w_merge[DATA_W-1:0];
                    end
                end
            end
            StFlush: begin
                if (w_out_free) begin
                    w_m_tvalid_d = 1'b1;
                    w_m_tdata_d  = r_buf;
                    w_m_tkeep_d  = low_mask({1'b0, r_occ});
                    w_m_tlast_d  = 1'b1;
                    w_occ_d      = '0;
                    w_buf_d      = '0;
                    w_state_d    = StAccum;
                end
            end
            default: w_state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StAccum;
            r_occ      <= '0;
            r_buf      <= '0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_err_keep <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_occ      <= w_occ_d;
            r_buf      <= w_buf_d;
            r_m_tdata  <= w_m_tdata_d;
            r_m_tkeep  <= w_m_tkeep_d;
            r_m_tvalid <= w_m_tvalid_d;
            r_m_tlast  <= w_m_tlast_d;
            r_err_keep <= r_err_keep || (w_accept && !w_contig);
        end
    end

    assign m_tdata  = r_m_tdata;
    assign m_tkeep  = r_m_tkeep;
    assign m_tvalid = r_m_tvalid;
    assign m_tlast  = r_m_tlast;
    assign err_keep = r_err_keep;

`ifdef PACKER_STATS_EN
    logic [CNT_W-1:0] r_stat_bytes_in, r_stat_beats_out, r_stat_frames_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_bytes_in   <= '0;
            r_stat_beats_out  <= '0;
            r_stat_frames_out <= '0;
        end else begin
            if (w_accept) begin
                r_stat_bytes_in <= r_stat_bytes_in + CNT_W'(w_count);
            end
            if (r_m_tvalid && m_tready) begin
                r_stat_beats_out <= r_stat_beats_out + 1'b1;
                if (r_m_tlast) begin
                    r_stat_frames_out <= r_stat_frames_out + 1'b1;
                end
            end
        end
    end

    assign stat_bytes_in   = r_stat_bytes_in;
    assign stat_beats_out  = r_stat_beats_out;
    assign stat_frames_out = r_stat_frames_out;
`endif

endmodule
